// File: rtl/reg_cmd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_cmd_ctrl_if : byte stream, register file and transmit-side signals     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface reg_cmd_ctrl_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [BYTE_WIDTH-1:0] RX_D;
  logic                  RX_D_VLD;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_VLD;
  logic                  TX_RDY;
  logic                  BUSY;
  logic                  ERR;

  modport master (
    output RX_D, RX_D_VLD, RdData, TX_RDY,
    input  WrEn, RdEn, Address, WrData, TX_DATA, TX_VLD, BUSY, ERR
  );

  modport slave (
    input  RX_D, RX_D_VLD, RdData, TX_RDY,
    output WrEn, RdEn, Address, WrData, TX_DATA, TX_VLD, BUSY, ERR
  );
endinterface
`default_nettype wire

// File: rtl/reg_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_cmd_ctrl : parses write/read frames from a byte stream into register   |
// | file strobes and returns read data over a valid/ready handshake.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reg_cmd_ctrl #(
  parameter int                  BYTE_WIDTH     = 8,
  parameter int                  DATA_WIDTH     = 16,
  parameter int                  ADDR_WIDTH     = 3,
  parameter logic [BYTE_WIDTH-1:0] WR_CMD       = 8'hAA,
  parameter logic [BYTE_WIDTH-1:0] RD_CMD       = 8'hBB,
  parameter int                  TIMEOUT_CYCLES = 255
) (
  input  logic            CLK,
  input  logic            RST,
  reg_cmd_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_ADDR  = 4'd1,
    S_WR_LSB   = 4'd2,
    S_WR_MSB   = 4'd3,
    S_WR_ISSUE = 4'd4,
    S_RD_ADDR  = 4'd5,
    S_RD_ISSUE = 4'd6,
    S_RD_WAIT  = 4'd7,
    S_RD_OUT   = 4'd8
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic                  err_q, err_d;
  logic                  wren_q, rden_q, busy_q, txvld_q;
  logic                  w_in_frame;
  logic                  w_busy_next;
  logic                  w_addr_bad;

  assign w_addr_bad  = |bus.RX_D[BYTE_WIDTH-1:ADDR_WIDTH];
  assign w_in_frame  = (state_q == S_WR_ADDR) || (state_q == S_WR_LSB) ||
                       (state_q == S_WR_MSB)  || (state_q == S_RD_ADDR);
  assign w_busy_next = (state_d == S_WR_ISSUE) || (state_d == S_RD_ISSUE) ||
                       (state_d == S_RD_WAIT)  || (state_d == S_RD_OUT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_D == WR_CMD)      state_d = S_WR_ADDR;
          else if (bus.RX_D == RD_CMD) state_d = S_RD_ADDR;
        end
      end
      S_WR_ADDR, S_RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_d = bus.RX_D[ADDR_WIDTH-1:0];
          if (w_addr_bad) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = (state_q == S_WR_ADDR) ? S_WR_LSB : S_RD_ISSUE;
          end
        end
      end
      S_WR_LSB: begin
        if (bus.RX_D_VLD) begin
          wdata_d[BYTE_WIDTH-1:0] = bus.RX_D;
          state_d                 = S_WR_MSB;
        end
      end
      S_WR_MSB: begin
        if (bus.RX_D_VLD) begin
          wdata_d[DATA_WIDTH-1:BYTE_WIDTH] = bus.RX_D;
          state_d                          = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // Register file has presented RdData by now
        txd_d   = bus.RdData;
        state_d = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (bus.TX_RDY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (busy_q && bus.RX_D_VLD) err_d = 1'b1;

    if (w_in_frame) begin
      if (bus.RX_D_VLD) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      err_q   <= 1'b0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
      txvld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
      wren_q  <= (state_d == S_WR_ISSUE);
      rden_q  <= (state_d == S_RD_ISSUE);
      busy_q  <= w_busy_next;
      txvld_q <= (state_d == S_RD_OUT);
    end
  end

  assign bus.WrEn    = wren_q;
  assign bus.RdEn    = rden_q;
  assign bus.Address = addr_q;
  assign bus.WrData  = wdata_q;
  assign bus.TX_DATA = txd_q;
  assign bus.TX_VLD  = txvld_q;
  assign bus.BUSY    = busy_q;
  assign bus.ERR     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_cmd_ctrl : directed frames against a per-cycle expectation timeline |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_reg_cmd_ctrl;

  localparam int N = 1024;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  reg_cmd_ctrl_if #(.BYTE_WIDTH(8), .DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

  reg_cmd_ctrl #(
    .BYTE_WIDTH(8), .DATA_WIDTH(16), .ADDR_WIDTH(3),
    .WR_CMD(8'hAA), .RD_CMD(8'hBB), .TIMEOUT_CYCLES(255)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Register file environment, preloaded on the first edge
  logic [15:0] rf [8];
  bit          rf_loaded;
  always @(posedge CLK) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      rf[3]      <= 16'hBEEF;
      rf[4]      <= 16'hC0DE;
      bus.RdData <= 16'h0000;
      rf_loaded  <= 1'b1;
    end else begin
      if (bus.WrEn) rf[bus.Address] <= bus.WrData;
      if (bus.RdEn) bus.RdData <= rf[bus.Address];
    end
  end

  // Expected timeline, indexed by cycle; zero everywhere unless a frame says otherwise
  bit          e_wr [N];
  bit          e_rd [N];
  bit          e_err[N];
  bit          e_busy[N];
  bit          e_vld[N];
  logic [2:0]  e_a  [N];
  logic [15:0] e_wd [N];
  logic [15:0] e_td [N];
  logic [15:0] mdl  [8];

  int total = 0;
  int bad   = 0;

  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  logic [2:0]  wl_a [4];
  logic [15:0] wl_d [4];
  logic [15:0] rl_d [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (cyc < N) begin
      chk("WrEn",   32'(bus.WrEn),   32'(e_wr[cyc]));
      chk("RdEn",   32'(bus.RdEn),   32'(e_rd[cyc]));
      chk("ERR",    32'(bus.ERR),    32'(e_err[cyc]));
      chk("BUSY",   32'(bus.BUSY),   32'(e_busy[cyc]));
      chk("TX_VLD", 32'(bus.TX_VLD), 32'(e_vld[cyc]));
      if (e_wr[cyc]) begin
        chk("wr_Address", 32'(bus.Address), 32'(e_a[cyc]));
        chk("WrData",     32'(bus.WrData),  32'(e_wd[cyc]));
      end
      if (e_rd[cyc]) chk("rd_Address", 32'(bus.Address), 32'(e_a[cyc]));
      if (e_vld[cyc]) chk("TX_DATA", 32'(bus.TX_DATA), 32'(e_td[cyc]));
    end
    if (bus.WrEn) begin
      if (wr_cnt < 4) begin
        wl_a[wr_cnt] = bus.Address;
        wl_d[wr_cnt] = bus.WrData;
      end
      wr_cnt++;
    end
    if (bus.TX_VLD && bus.TX_RDY) begin
      if (rd_cnt < 4) rl_d[rd_cnt] = bus.TX_DATA;
      rd_cnt++;
    end
    if (bus.ERR) err_cnt++;
  end

  task automatic sched_write(input int c, input logic [2:0] a, input logic [15:0] d);
    e_wr[c]   = 1'b1;
    e_busy[c] = 1'b1;
    e_a[c]    = a;
    e_wd[c]   = d;
    mdl[a]    = d;
  endtask

  // c = RdEn cycle; data is valid from c+2 and accepted at c+2+hold
  task automatic sched_read(input int c, input logic [2:0] a, input int hold);
    e_rd[c] = 1'b1;
    e_a[c]  = a;
    for (int k = 0; k <= 2 + hold; k++) e_busy[c+k] = 1'b1;
    for (int k = 2; k <= 2 + hold; k++) begin
      e_vld[c+k] = 1'b1;
      e_td[c+k]  = mdl[a];
    end
  endtask

  task automatic sched_err(input int c);
    e_err[c] = 1'b1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit r);
    bus.RX_D_VLD = v;
    bus.RX_D     = d;
    bus.TX_RDY   = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic write_frame(input logic [2:0] a, input logic [7:0] lsb, input logic [7:0] msb);
    int n;
    n = cyc;
    sched_write(n + 4, a, {msb, lsb});
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, {5'd0, a}, 1'b0);
    drive(1'b1, lsb, 1'b0);
    drive(1'b1, msb, 1'b0);
  endtask

  // inj >= 0 injects an AA byte at frame-relative cycle inj
  task automatic read_frame(input logic [2:0] a, input int hold, input int inj);
    int n;
    n = cyc;
    sched_read(n + 2, a, hold);
    drive(1'b1, 8'hBB, 1'b0);
    drive(1'b1, {5'd0, a}, 1'b0);
    for (int c = n + 2; c <= n + 4 + hold; c++) begin
      if (inj >= 0 && c == n + inj) begin
        sched_err(c + 1);
        drive(1'b1, 8'hAA, c == n + 4 + hold);
      end else begin
        drive(1'b0, 8'h00, c == n + 4 + hold);
      end
    end
  endtask

  initial begin
    int n;
    bus.RX_D     = 8'h00;
    bus.RX_D_VLD = 1'b0;
    bus.TX_RDY   = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    mdl[3] = 16'hBEEF;
    mdl[4] = 16'hC0DE;

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(2);

    write_frame(3'd5, 8'h34, 8'h12);
    idle(3);

    read_frame(3'd3, 5, -1);
    idle(2);

    n = cyc;
    sched_err(n + 2);
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'h09, 1'b0);
    idle(2);
    write_frame(3'd1, 8'hFF, 8'h00);
    idle(3);

    n = cyc;
    sched_err(n + 258);
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h11, 1'b0);
    idle(255);
    drive(1'b1, 8'h00, 1'b0);
    idle(3);

    read_frame(3'd4, 4, 5);
    idle(2);

    n = cyc;
    e_rd[n+2]   = 1'b1;
    e_a[n+2]    = 3'd4;
    e_busy[n+2] = 1'b1;
    drive(1'b1, 8'hBB, 1'b0);
    drive(1'b1, 8'h04, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(1);
    read_frame(3'd4, 0, -1);
    idle(3);

    chk("wr_count",  32'(wr_cnt),  32'd2);
    chk("wr0_addr",  32'(wl_a[0]), 32'd5);
    chk("wr0_data",  32'(wl_d[0]), 32'h1234);
    chk("wr1_addr",  32'(wl_a[1]), 32'd1);
    chk("wr1_data",  32'(wl_d[1]), 32'h00FF);
    chk("rd_count",  32'(rd_cnt),  32'd3);
    chk("rd0_data",  32'(rl_d[0]), 32'hBEEF);
    chk("rd1_data",  32'(rl_d[1]), 32'hC0DE);
    chk("rd2_data",  32'(rl_d[2]), 32'hC0DE);
    chk("err_count", 32'(err_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
